mem_line_responder: RTL

- Main-memory responder on the cache's miss side: serves line-fill reads and line writebacks issued by the cache controller when the cache arrays miss or evict.
- Accepts one line request at a time and waits a programmable access latency.
- Then streams LINE_WORDS words out (read) or sinks LINE_WORDS words in (write), one word per clock.
- Behavioural backing store for CPU simulation, synthesizable as a single-port array.

---
 rtl/mem_line_pkg.sv | 7 +
 rtl/mem_word_array.sv | 24 ++
 rtl/mem_line_responder.sv | 98 +++++++++
 3 files changed

// File: rtl/mem_line_pkg.sv
// mem_line_pkg: shared types and defaults for the line-fill/writeback memory responder
package mem_line_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RD_BURST, WR_BURST} state_t;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_LINE_WORDS = 4;
    localparam int LINE_OFF_W = $clog2(MEM_LINE_WORDS);
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: single-port word store with synchronous clear, synchronous write, asynchronous read
module mem_word_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**DEPTH_LOG2; i++) mem[i] <= '0;
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/mem_line_responder.sv
// mem_line_responder: serves line fills and writebacks after a fixed access latency, one word per clock
module mem_line_responder import mem_line_pkg::*; #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = MEM_DATA_W,
    parameter int LINE_WORDS = MEM_LINE_WORDS,
    parameter int LATENCY = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_last
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int LAT_W = $clog2(LATENCY + 1);
    localparam int LINE_W = DEPTH_LOG2 - OFF_W;

    state_t            state, state_n;
    logic [LAT_W-1:0]  lat_cnt, lat_n;
    logic [OFF_W-1:0]  beat, beat_n;
    logic [LINE_W-1:0] line, line_n;
    logic              wflag, wflag_n;
    logic [DATA_W-1:0] mem_rdata;
    logic              end_beat;
    logic              unused_addr;

    // Only the line index within the store matters: offset bits are dropped, upper bits alias
    assign unused_addr = ^{req_addr[ADDR_W-1:DEPTH_LOG2], req_addr[OFF_W-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            lat_cnt <= '0;
            beat    <= '0;
            line    <= '0;
            wflag   <= 1'b0;
        end else begin
            state   <= state_n;
            lat_cnt <= lat_n;
            beat    <= beat_n;
            line    <= line_n;
            wflag   <= wflag_n;
        end
    end

    assign end_beat = beat == OFF_W'(LINE_WORDS - 1);

    always_comb begin
        state_n = state;
        lat_n   = lat_cnt;
        beat_n  = beat;
        line_n  = line;
        wflag_n = wflag;
        case (state)
            IDLE: if (req_valid) begin
                state_n = WAIT;
                lat_n   = LAT_W'(LATENCY - 1);
                line_n  = req_addr[DEPTH_LOG2-1:OFF_W];
                wflag_n = req_write;
            end
            WAIT: if (lat_cnt == '0) begin
                beat_n  = '0;
                state_n = wflag ? WR_BURST : RD_BURST;
            end else begin
                lat_n = lat_cnt - 1'b1;
            end
            RD_BURST, WR_BURST: begin
                beat_n  = beat + 1'b1;
                state_n = end_beat ? IDLE : state;
            end
            default: state_n = IDLE;
        endcase
    end

    assign req_ready = state == IDLE;
    assign rd_valid  = state == RD_BURST;
    assign wr_ready  = state == WR_BURST;
    assign rd_last   = rd_valid && end_beat;
    assign wr_last   = wr_ready && end_beat;
    assign rd_data   = rd_valid ? mem_rdata : '0;

    mem_word_array #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_ready),
        .addr ({line, beat}),
        .wdata(wr_data),
        .rdata(mem_rdata)
    );
endmodule
